// File: rtl/cpu_param.sv
// cpu_param: multi-cycle accumulator CPU with 4-entry register file, Z/C flags and two-word ops.
module cpu_param #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic [AW-1:0]   mem_address,
   input  logic [DW-1:0]   mem_data_r,
   output logic [DW-1:0]   mem_data_w,
   output logic            mem_we,
   output logic [2:0]      dbg_state,
   output logic [AW-1:0]   dbg_pc,
   output logic [4*DW-1:0] dbg_regs,
   output logic            dbg_z,
   output logic            dbg_c,
   output logic            dbg_halted,
   output logic [15:0]     dbg_icount
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      OPADDR = 3'd2,
      OPREAD = 3'd3,
      EXEC   = 3'd4,
      MEMRD  = 3'd5,
      HALT   = 3'd7
   } state_t;
   state_t             state;
   logic [AW-1:0]      pc;
   logic [3:0][DW-1:0] regs;
   logic [7:0]         ir;
   logic [DW-1:0]      operand;
   logic               z, c;
   logic [15:0]        icount;
   logic [3:0]         op, mop;
   logic [1:0]         rd, rs;
   logic [DW-1:0]      a, b;
   logic [DW:0]        res;
   assign op  = ir[7:4];
   assign rd  = ir[3:2];
   assign rs  = ir[1:0];
   assign mop = mem_data_r[7:4];
   // Bit DW of res is carry for add/inc, borrow for sub/dec, and 0 for logic ops.
   always_comb begin
      a = regs[rd];
      b = regs[rs];
      res = op == 4'h8 ? {1'b0, a} + {1'b0, b}
          : op == 4'h9 ? {1'b0, a} - {1'b0, b}
          : op == 4'hA ? {1'b0, a & b}
          : op == 4'hB ? {1'b0, a | b}
          : op == 4'hC ? {1'b0, a ^ b}
          : op == 4'hD ? {1'b0, a} + (DW+1)'(1)
          : {1'b0, a} - (DW+1)'(1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FETCH;
         pc          <= '0;
         regs        <= '0;
         ir          <= '0;
         operand     <= '0;
         z           <= 1'b0;
         c           <= 1'b0;
         icount      <= '0;
         mem_address <= '0;
         mem_data_w  <= '0;
         mem_we      <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               mem_address <= pc;
               mem_we      <= 1'b0;
               state       <= DECODE;
            end
            DECODE: begin
               ir    <= mem_data_r[7:0];
               pc    <= pc + AW'(1);
               state <= mop == 4'hF ? HALT : (mop != 4'h0 && mop < 4'h7) ? OPADDR : EXEC;
               if (mop == 4'hF) icount <= icount + 16'd1;
            end
            OPADDR: begin
               mem_address <= pc;
               state       <= OPREAD;
            end
            OPREAD: begin
               operand <= mem_data_r;
               pc      <= pc + AW'(1);
               state   <= EXEC;
            end
            EXEC: begin
               case (op)
                  4'h1: pc <= operand[AW-1:0];
                  4'h2: if (z) pc <= operand[AW-1:0];
                  4'h3: if (!z) pc <= operand[AW-1:0];
                  4'h4: regs[rd] <= operand;
                  4'h5: mem_address <= operand[AW-1:0];
                  4'h6: begin
                     mem_address <= operand[AW-1:0];
                     mem_data_w  <= regs[rd];
                     mem_we      <= 1'b1;
                  end
                  4'h7: regs[rd] <= regs[rs];
                  default: if (op[3]) begin
                     regs[rd] <= res[DW-1:0];
                     z        <= res[DW-1:0] == '0;
                     c        <= res[DW];
                  end
               endcase
               state <= op == 4'h5 ? MEMRD : FETCH;
               if (op != 4'h5) icount <= icount + 16'd1;
            end
            MEMRD: begin
               regs[rd] <= mem_data_r;
               icount   <= icount + 16'd1;
               state    <= FETCH;
            end
            HALT: state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end
   assign dbg_state  = state;
   assign dbg_pc     = pc;
   assign dbg_regs   = regs;
   assign dbg_z      = z;
   assign dbg_c      = c;
   assign dbg_halted = state == HALT;
   assign dbg_icount = icount;
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed programs from the test plan plus random programs checked against an ISA-level model.
module tb_cpu_param;
   localparam int DW = 8, AW = 8;
   logic clk = 1'b0, reset_n = 1'b0, load = 1'b0;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_r, mem_data_w;
   logic mem_we;
   logic [2:0] dbg_state;
   logic [AW-1:0] dbg_pc;
   logic [4*DW-1:0] dbg_regs;
   logic dbg_z, dbg_c, dbg_halted;
   logic [15:0] dbg_icount;
   logic [7:0] mem[256], img[256], mm[256], mr[4];
   logic mz, mc;
   logic [7:0] mpc;
   logic [15:0] mcnt;
   int mcyc, compares = 0, fails = 0, we_total = 0;

   cpu_param #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_data_r(mem_data_r),
      .mem_data_w(mem_data_w), .mem_we(mem_we), .dbg_state(dbg_state), .dbg_pc(dbg_pc),
      .dbg_regs(dbg_regs), .dbg_z(dbg_z), .dbg_c(dbg_c), .dbg_halted(dbg_halted),
      .dbg_icount(dbg_icount)
   );

   always #5 clk = ~clk;
   assign mem_data_r = mem[mem_address];
   always @(posedge clk) begin
      if (load) mem <= img;
      else if (mem_we) mem[mem_address] <= mem_data_w;
   end
   always @(negedge clk) if (mem_we) we_total++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(output int cyc);
      reset_n = 1'b0;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      while (!dbg_halted && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Instruction-level interpreter: one loop iteration per instruction, latency from the op class.
   task automatic model();
      logic [7:0] ins, opr;
      logic [3:0] op;
      logic [1:0] d, s;
      int x, y, r;
      mpc = 0; mz = 0; mc = 0; mcnt = 0; mcyc = 0; opr = 0;
      mr = '{default: 8'h00};
      mm = img;
      for (int k = 0; k < 2000; k++) begin
         ins = mm[mpc]; mpc++;
         op = ins[7:4]; d = ins[3:2]; s = ins[1:0];
         mcnt++;
         if (op == 4'hF) begin mcyc += 2; break; end
         if (op >= 1 && op <= 6) begin opr = mm[mpc]; mpc++; end
         mcyc += (op == 5) ? 6 : (op >= 1 && op <= 6) ? 5 : 3;
         x = mr[d]; y = mr[s];
         case (op)
            4'h1: mpc = opr;
            4'h2: if (mz) mpc = opr;
            4'h3: if (!mz) mpc = opr;
            4'h4: mr[d] = opr;
            4'h5: mr[d] = mm[opr];
            4'h6: mm[opr] = mr[d];
            4'h7: mr[d] = mr[s];
            4'h0: ;
            default: begin
               case (op)
                  4'h8: r = x + y;
                  4'h9: r = x - y;
                  4'hA: r = x & y;
                  4'hB: r = x | y;
                  4'hC: r = x ^ y;
                  4'hD: r = x + 1;
                  default: r = x - 1;
               endcase
               mc = (op == 8 || op == 13) ? (r > 255) : (op == 9 || op == 14) ? (r < 0) : 1'b0;
               mr[d] = r[7:0];
               mz = (r[7:0] == 8'h00);
            end
         endcase
      end
   endtask

   task automatic gen();
      int n, addr, at[33];
      logic [3:0] ops[32];
      img = '{default: 8'h00};
      for (int i = 128; i < 256; i++) img[i] = 8'($urandom);
      n = $urandom_range(8, 24);
      addr = 0;
      for (int i = 0; i < n; i++) begin
         ops[i] = 4'($urandom_range(0, 14));
         at[i] = addr;
         addr += (ops[i] >= 1 && ops[i] <= 6) ? 2 : 1;
      end
      at[n] = addr;
      for (int i = 0; i < n; i++) begin
         img[at[i]] = {ops[i], 2'($urandom), 2'($urandom)};
         if (ops[i] >= 1 && ops[i] <= 3) img[at[i] + 1] = 8'(at[$urandom_range(i + 1, n)]);
         else if (ops[i] == 4) img[at[i] + 1] = 8'($urandom);
         else if (ops[i] == 5 || ops[i] == 6) img[at[i] + 1] = 8'h80 | 8'($urandom_range(0, 127));
      end
      img[at[n]] = 8'hF0;
   endtask

   initial begin
      int cyc, we0, bad;
      // Basic program
      img = '{default: 8'h00};
      img[0] = 8'h40; img[1] = 8'h05; img[2] = 8'h44; img[3] = 8'h03;
      img[4] = 8'h81; img[5] = 8'h60; img[6] = 8'h20; img[7] = 8'hF0;
      reset_n = 1'b0;
      #2;
      check("reset_state", dbg_state, 0);
      check("reset_pc", dbg_pc, 0);
      check("reset_regs", dbg_regs, 0);
      check("reset_flags", {dbg_z, dbg_c}, 0);
      check("reset_mem_out", {mem_address, mem_data_w, mem_we}, 0);
      check("reset_icount", dbg_icount, 0);
      we0 = we_total;
      run(cyc);
      check("basic_halted", dbg_halted, 1);
      check("basic_mem20", mem[8'h20], 8'h08);
      check("basic_r0", dbg_regs[7:0], 8'h08);
      check("basic_r1", dbg_regs[15:8], 8'h03);
      check("basic_pc", dbg_pc, 8'h08);
      check("basic_icount", dbg_icount, 5);
      check("basic_we_cycles", we_total - we0, 1);
      check("basic_cycles", cyc, 20);
      // SUB borrow, then SUB r,r
      img = '{default: 8'h00};
      img[0] = 8'h40; img[1] = 8'h02; img[2] = 8'h44; img[3] = 8'h03; img[4] = 8'h91; img[5] = 8'hF0;
      run(cyc);
      check("sub_r0", dbg_regs[7:0], 8'hFF);
      check("sub_c", dbg_c, 1);
      check("sub_z", dbg_z, 0);
      img[5] = 8'h95; img[6] = 8'hF0;
      run(cyc);
      check("subrr_r1", dbg_regs[15:8], 8'h00);
      check("subrr_z", dbg_z, 1);
      check("subrr_c", dbg_c, 0);
      // Counted loop
      img = '{default: 8'h00};
      img[0] = 8'h48; img[1] = 8'h03; img[2] = 8'hE8; img[3] = 8'h30; img[4] = 8'h02; img[5] = 8'hF0;
      run(cyc);
      check("loop_r2", dbg_regs[23:16], 8'h00);
      check("loop_flags", {dbg_z, dbg_c}, 2'b10);
      check("loop_icount", dbg_icount, 8);
      check("loop_cycles", cyc, 31);
      // LD timing
      img = '{default: 8'h00};
      img[0] = 8'h5C; img[1] = 8'h30; img[2] = 8'hF0; img[8'h30] = 8'hA5;
      we0 = we_total;
      run(cyc);
      check("ld_r3", dbg_regs[31:24], 8'hA5);
      check("ld_cycles", cyc, 8);
      check("ld_no_we", we_total - we0, 0);
      // PC wrap
      img = '{default: 8'h00};
      img[0] = 8'h10; img[1] = 8'hFF;
      run(cyc);
      reset_n = 1'b0;
      load = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("wrap_jmp_pc", dbg_pc, 8'hFF);
      repeat (3) @(negedge clk);
      check("wrap_pc", dbg_pc, 8'h00);
      check("wrap_state", dbg_state, 0);
      @(negedge clk);
      check("wrap_fetch_addr", mem_address, 8'h00);
      // Reset during ST's mem_we cycle
      img = '{default: 8'h00};
      img[0] = 8'h40; img[1] = 8'h5A; img[2] = 8'h60; img[3] = 8'h20; img[4] = 8'hF0; img[8'h20] = 8'h11;
      reset_n = 1'b0;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      while (!mem_we && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("st_we_seen", {mem_we, 8'(cyc)}, {1'b1, 8'd10});
      reset_n = 1'b0;
      #1;
      check("st_rst_we", mem_we, 0);
      check("st_rst_pc", dbg_pc, 0);
      check("st_rst_state", dbg_state, 0);
      @(posedge clk);
      #1;
      check("st_rst_mem", mem[8'h20], 8'h11);
      // Random programs against the model
      for (int t = 0; t < 12; t++) begin
         gen();
         model();
         run(cyc);
         check("rnd_halted", dbg_halted, 1);
         check("rnd_regs", dbg_regs, {mr[3], mr[2], mr[1], mr[0]});
         check("rnd_flags", {dbg_z, dbg_c}, {mz, mc});
         check("rnd_pc", dbg_pc, mpc);
         check("rnd_icount", dbg_icount, mcnt);
         check("rnd_cycles", cyc, mcyc);
         bad = 0;
         for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
         check("rnd_mem", bad, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end
endmodule
